// File: rtl/traffic_pkg.sv
// Shared phase encoding for the intersection sequencer and lamp decoder.
// Adjacent phases differ in one bit so the decoder never sees a glitch code.
package traffic_pkg;

  localparam logic [1:0] p_S0 = 2'b00;
  localparam logic [1:0] p_S1 = 2'b01;
  localparam logic [1:0] p_S2 = 2'b11;
  localparam logic [1:0] p_S3 = 2'b10;

  typedef enum logic [1:0] {
    PH_S0 = p_S0,
    PH_S1 = p_S1,
    PH_S2 = p_S2,
    PH_S3 = p_S3
  } phase_e;

  function automatic bit durations_legal(
    input int unsigned long_c,
    input int unsigned short_c,
    input int unsigned cnt_w
  );
    longint unsigned lim;
    lim = longint'(1) << cnt_w;
    return (long_c >= 1) && (short_c >= 1) &&
           (longint'(long_c) <= lim) &&
           (longint'(short_c) <= lim);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; saturates at zero and flags it.
// Load has priority over counting.
module phase_timer #(
  parameter int unsigned         p_CNT_W   = 8,
  parameter logic [p_CNT_W-1:0]  p_RST_VAL = '0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_En,
  input  logic               i_Load,
  input  logic [p_CNT_W-1:0] i_Load_val,
  output logic               o_Zero
);

  logic [p_CNT_W-1:0] cnt_q;
  logic [p_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Load) begin
      cnt_d = i_Load_val;
    end else if (i_En && (cnt_q != '0)) begin
      cnt_d = cnt_q - p_CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q <= p_RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_sequencer.sv
// Four-phase main/side intersection sequencer with latched side demand.
// Main road holds green until a side request arrives after its minimum.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned p_LONG_CYCLES  = 8,
  parameter int unsigned p_SHORT_CYCLES = 3,
  parameter int unsigned p_CNT_W        = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic       i_Side_req,
  output logic [1:0] o_G,
  output logic       o_Phase_done,
  output logic       o_Side_pending
);

  localparam bit LEGAL =
    durations_legal(p_LONG_CYCLES, p_SHORT_CYCLES, p_CNT_W);

  if (!LEGAL) begin : g_bad_params
    $error("traffic_sequencer: duration parameters out of range");
  end

  localparam logic [p_CNT_W-1:0] LONG_M1  = p_CNT_W'(p_LONG_CYCLES - 1);
  localparam logic [p_CNT_W-1:0] SHORT_M1 = p_CNT_W'(p_SHORT_CYCLES - 1);

  phase_e             g_q;
  phase_e             g_d;
  logic               pend_q;
  logic               pend_d;
  logic               done_q;
  logic               done_d;
  logic               zero;
  logic               expiry;
  logic               chg;
  logic [p_CNT_W-1:0] load_val;

  assign expiry = i_Enable && zero;

  always_comb begin
    g_d      = g_q;
    pend_d   = pend_q;
    chg      = 1'b0;
    load_val = LONG_M1;
    done_d   = 1'b0;

    if (expiry) begin
      unique case (g_q)
        PH_S0: if (pend_q || i_Side_req) g_d = PH_S1;
        PH_S1: g_d = PH_S2;
        PH_S2: g_d = PH_S3;
        PH_S3: g_d = PH_S0;
        default: g_d = PH_S0;
      endcase
    end

    chg    = (g_d != g_q);
    done_d = chg;

    unique case (1'b1)
      (g_d == PH_S1),
      (g_d == PH_S3): load_val = SHORT_M1;
      default:        load_val = LONG_M1;
    endcase

    // Side road is already green in S2, so its requests are dropped.
    if (i_Side_req && (g_q != PH_S2)) pend_d = 1'b1;
    if ((g_q == PH_S1) && (g_d == PH_S2)) pend_d = 1'b0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      g_q    <= PH_S0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      g_q    <= g_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end

  phase_timer #(
    .p_CNT_W   (p_CNT_W),
    .p_RST_VAL (LONG_M1)
  ) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_En       (i_Enable),
    .i_Load     (chg),
    .i_Load_val (load_val),
    .o_Zero     (zero)
  );

  assign o_G            = g_q;
  assign o_Phase_done   = done_q;
  assign o_Side_pending = pend_q;

endmodule
